uc_rr_arbiter: RTL
==================

UC_RR_ARBITER -- requirements
Module: uc_rr_arbiter

Interface
REQ-001 Parameter NUM_ENG, default 4: number of solver engines, 2..16.
REQ-002 Parameter LIT_W, default 8: signed literal width; magnitude is the variable index, sign is the polarity (negative = 1).
REQ-003 Parameter Q_DEPTH, default 8: broadcast queue depth, power of two, at least 2.
REQ-004 Ports, each given as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous restart: returns to IDLE and wipes the table and queue.
- init_valid / init_ready  in / out  1 / 1  handshake for initial unit clauses from memory.
- init_lit  in  LIT_W  initial literal.
- init_done  in  1  last initial literal has been sent.
- eng_valid / eng_ready  in / out  NUM_ENG / NUM_ENG  per-engine unit-clause handshake.
- eng_lit  in  NUM_ENG*LIT_W  per-engine literal; engine i occupies slice i.
- bcast_valid  out  1  queue head is valid.
- bcast_lit  out  LIT_W  queue head literal.
- bcast_ready  in  NUM_ENG  per-engine accept.
- conflict  out  1  sticky conflict flag.
- conflict_var  out  LIT_W-1  index of the conflicting variable.
- busy  out  1  state is not IDLE, or the queue is non-empty.

Function
REQ-005 States and transitions:
- IDLE -> LOAD on the first init_valid.
- LOAD -> ARB on init_done, or on init_done with an accepted final literal in the same cycle.
- LOAD or ARB -> CONFLICT on a detected conflict.
- Any state -> IDLE on clear.
REQ-006 Literal check:
- A literal is accepted when its handshake completes (valid & ready).
- Its 2-bit table entry {neg_seen, pos_seen} is read combinationally from the registered table.
REQ-007 Opposite-polarity bit already set: conflict is asserted next cycle, conflict_var latched, and the literal is not pushed.
REQ-008 Same-polarity bit already set: the literal is dropped as a duplicate; no push, no table change.
REQ-009 Otherwise: set the polarity bit and push the literal to the queue in the same cycle.
REQ-010 Literal 0 and literal -2^(LIT_W-1) are illegal: accepted, then silently discarded.
REQ-011 init_ready = 1 only in IDLE/LOAD with the queue not full; eng_ready = 0 outside ARB.
REQ-012 ARB: round-robin grant; eng_ready is one-hot to the lowest valid engine at or after the pointer, and only when the queue is not full.
REQ-013 The pointer advances to granted+1 (mod NUM_ENG) after an accepted grant, and holds otherwise.
REQ-014 A pushed literal appears on bcast_lit no earlier than the next cycle; no bypass.
REQ-015 Broadcast pop occurs when bcast_valid & (&bcast_ready); all engines accept in the same cycle.
REQ-016 Push and pop in the same cycle on a full queue: allowed only when pop is true in that cycle; ready is computed from the registered full flag.
REQ-017 CONFLICT: conflict = 1, bcast_valid = 0, all readies 0, queue flushed; held until clear or reset.
REQ-018 clear has priority over every other event in the same cycle.

Reset
REQ-019 On rst low, asynchronously:
- State = IDLE, table all zero, queue empty, pointer = 0.
- conflict = 0, conflict_var = 0, all readies 0, bcast_valid = 0, busy = 0.
- Statistics counters, if present, = 0.
REQ-020 Reset deassertion mid-operation discards all in-flight literals; no output glitches high during reset.

Configuration
REQ-021 Macro UCA_STATS_EN defined: adds 16-bit saturating outputs.
- dup_cnt counts duplicate drops.
- acc_cnt counts queue pushes.
- Both are cleared by clear and by rst.
REQ-022 UCA_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.

Structure
REQ-023 Package uc_pkg holds the state enum (IDLE, LOAD, ARB, CONFLICT) and the table-entry encoding constants: NONE = 0, POS = 1, NEG = 2.
REQ-024 The queue is sub-module uc_lit_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, head), instantiated once.

Verification
REQ-025 LOAD +3, -5, +3, then init_done -> two pushes; bcast_lit shows 3 then 5 with sign negative; state ARB.
REQ-026 ARB with engines 0, 2 and 3 all valid, pointer 0, queue empty -> grants 0, 2, 3 on consecutive cycles; the pointer wraps to 0.
REQ-027 Table holds +7; engine 1 sends -7 -> conflict = 1 the next cycle, conflict_var = 7, queue empty, all readies 0.
REQ-028 Q_DEPTH = 4 with bcast_ready = 0 after 4 pushes -> eng_ready all 0; raise all bcast_ready -> one pop per cycle, and grants resume the cycle after the first pop.
REQ-029 Assert clear in the CONFLICT state, then load +7 -> no conflict; table wiped; state LOAD.
REQ-030 Pull rst low while the queue holds 3 entries -> busy = 0 and bcast_valid = 0 immediately; with UCA_STATS_EN defined, dup_cnt = 0.

Source files
------------

// File: rtl/uc_pkg.sv
// uc_pkg: shared types for the unit-clause arbiter (FSM state encoding, table-entry codes).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uc_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        ARB      = 2'd2,
        CONFLICT = 2'd3
    } uc_state_e;

    // Per-variable table entry {neg_seen, pos_seen}.
    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] POS  = 2'd1;
    localparam logic [1:0] NEG  = 2'd2;

    // Width of the optional statistics counters.
    localparam int STAT_W = 16;

endpackage

// File: rtl/uc_rr_arbiter_if.sv
// uc_rr_arbiter_if: handshake bundle between the solver engines/loader and the unit-clause arbiter.
// Latency: n/a (wires only).
// Backpressure: carries the valid/ready pairs; slave = arbiter side, master = engine/loader side.
// Signals: clear, init_* (initial literal stream), eng_* (per-engine unit clauses),
//          bcast_* (broadcast queue head), conflict/conflict_var, busy.
interface uc_rr_arbiter_if #(
    parameter int NUM_ENG = 4,
    parameter int LIT_W   = 8
);
    logic                     clear;
    logic                     init_valid;
    logic                     init_ready;
    logic [LIT_W-1:0]         init_lit;
    logic                     init_done;
    logic [NUM_ENG-1:0]       eng_valid;
    logic [NUM_ENG-1:0]       eng_ready;
    logic [NUM_ENG*LIT_W-1:0] eng_lit;
    logic                     bcast_valid;
    logic [LIT_W-1:0]         bcast_lit;
    logic [NUM_ENG-1:0]       bcast_ready;
    logic                     conflict;
    logic [LIT_W-2:0]         conflict_var;
    logic                     busy;

    modport slave (
        input  clear, init_valid, init_lit, init_done, eng_valid, eng_lit, bcast_ready,
        output init_ready, eng_ready, bcast_valid, bcast_lit, conflict, conflict_var, busy
    );

    modport master (
        output clear, init_valid, init_lit, init_done, eng_valid, eng_lit, bcast_ready,
        input  init_ready, eng_ready, bcast_valid, bcast_lit, conflict, conflict_var, busy
    );
endinterface

// File: rtl/uc_lit_fifo.sv
// uc_lit_fifo: synchronous literal queue; ports clk, rst, clr, push/push_dat, pop, full, empty, head.
// Latency: a pushed word is visible on head from the next cycle (no bypass).
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module uc_lit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_q] <= push_dat;
    end
endmodule

// File: rtl/uc_rr_arbiter.sv
// uc_rr_arbiter: dedups/conflict-checks unit literals from loader and engines, queues them for broadcast.
// Latency: accepted literal reaches bcast_lit one cycle later; conflict flag rises one cycle after detection.
// Backpressure: init/eng ready drop when the queue is full (registered flag); pop needs every engine ready.
// Ports: clk, rst (async active-low), bus (uc_rr_arbiter_if.slave); with UCA_STATS_EN defined, also
//        dup_cnt/acc_cnt (16-bit saturating duplicate-drop and push counters).
module uc_rr_arbiter
    import uc_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int LIT_W   = 8,
    parameter int Q_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    uc_rr_arbiter_if.slave bus
`ifdef UCA_STATS_EN
    ,
    output logic [STAT_W-1:0] dup_cnt,
    output logic [STAT_W-1:0] acc_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_ENG);
    localparam int IDX_W = LIT_W - 1;
    localparam int TBL_N = 1 << IDX_W;

    uc_state_e        state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [1:0]       tbl_q [TBL_N];
    logic [1:0]       tbl_d [TBL_N];
    logic [IDX_W-1:0] cvar_q, cvar_d;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_clr;
    logic [LIT_W-1:0] fifo_head;

    logic             gnt_found;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;
    logic             init_open, arb_open;
    logic             init_hs, eng_hs, acc;
    logic [LIT_W-1:0] lit;
    logic             lit_neg;
    logic [IDX_W-1:0] idx;
    logic             illegal;
    logic [1:0]       entry;
    logic             opp_seen, same_seen;
    logic             legal_acc, conf_det;

    // Round-robin search: first valid engine at or after the pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_ENG);
            if (!gnt_found && bus.eng_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Readies are gated by rst so nothing is offered while reset is held, and by clear so
    // no literal is taken in a restart cycle.
    assign init_open = rst & ~bus.clear & ~fifo_full & ((state_q == IDLE) | (state_q == LOAD));
    assign arb_open  = rst & ~bus.clear & ~fifo_full & (state_q == ARB);

    always_comb begin
        bus.eng_ready = '0;
        if (arb_open && gnt_found) bus.eng_ready[gnt_idx] = 1'b1;
    end
    assign bus.init_ready = init_open;

    assign init_hs = bus.init_valid & init_open;
    assign eng_hs  = arb_open & gnt_found;
    assign acc     = init_hs | eng_hs;
    assign lit     = init_hs ? bus.init_lit : bus.eng_lit[int'(gnt_idx)*LIT_W +: LIT_W];

    // Low bits of the two's-complement negation depend only on the low bits, so the index
    // can be formed without the sign bit. Index 0 covers both illegal codes (0 and most-negative).
    assign lit_neg   = lit[LIT_W-1];
    assign idx       = lit_neg ? (~lit[IDX_W-1:0] + IDX_W'(1)) : lit[IDX_W-1:0];
    assign illegal   = (idx == '0);
    assign entry     = tbl_q[idx];
    assign opp_seen  = lit_neg ? entry[0] : entry[1];
    assign same_seen = lit_neg ? entry[1] : entry[0];
    assign legal_acc = acc & ~illegal;
    assign conf_det  = legal_acc & opp_seen;
    assign fifo_push = legal_acc & ~opp_seen & ~same_seen;

    assign fifo_clr  = bus.clear | conf_det | (state_q == CONFLICT);
    assign fifo_pop  = bus.bcast_valid & (&bus.bcast_ready);

    assign bus.bcast_valid  = ~fifo_empty & (state_q != CONFLICT);
    assign bus.bcast_lit    = fifo_head;
    assign bus.conflict     = (state_q == CONFLICT);
    assign bus.conflict_var = cvar_q;
    assign bus.busy         = (state_q != IDLE) | ~fifo_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (init_hs) state_d = LOAD;
            LOAD:     if (conf_det) state_d = CONFLICT;
                      else if (bus.init_done) state_d = ARB;
            ARB:      if (conf_det) state_d = CONFLICT;
            CONFLICT: state_d = CONFLICT;
            default:  state_d = IDLE;
        endcase
        if (bus.clear) state_d = IDLE;
    end

    always_comb begin
        ptr_d  = ptr_q;
        cvar_d = cvar_q;
        tbl_d  = tbl_q;
        if (bus.clear) begin
            ptr_d  = '0;
            cvar_d = '0;
            for (int i = 0; i < TBL_N; i++) tbl_d[i] = NONE;
        end else begin
            if (eng_hs) ptr_d = (gnt_idx == PTR_W'(NUM_ENG - 1)) ? '0 : gnt_idx + 1'b1;
            if (conf_det) cvar_d = idx;
            if (fifo_push) tbl_d[idx] = entry | (lit_neg ? NEG : POS);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cvar_q  <= '0;
            for (int i = 0; i < TBL_N; i++) tbl_q[i] <= NONE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cvar_q  <= cvar_d;
            tbl_q   <= tbl_d;
        end
    end

    uc_lit_fifo #(
        .WIDTH (LIT_W),
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (fifo_clr),
        .push     (fifo_push),
        .push_dat (lit),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

`ifdef UCA_STATS_EN
    logic              dup_det;
    logic [STAT_W-1:0] dup_cnt_q, dup_cnt_d;
    logic [STAT_W-1:0] acc_cnt_q, acc_cnt_d;

    assign dup_det = legal_acc & ~opp_seen & same_seen;

    always_comb begin
        dup_cnt_d = dup_cnt_q;
        acc_cnt_d = acc_cnt_q;
        if (bus.clear) begin
            dup_cnt_d = '0;
            acc_cnt_d = '0;
        end else begin
            if (dup_det && (dup_cnt_q != '1))   dup_cnt_d = dup_cnt_q + 1'b1;
            if (fifo_push && (acc_cnt_q != '1)) acc_cnt_d = acc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dup_cnt_q <= '0;
            acc_cnt_q <= '0;
        end else begin
            dup_cnt_q <= dup_cnt_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign dup_cnt = dup_cnt_q;
    assign acc_cnt = acc_cnt_q;
`endif
endmodule
